// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle ops, NZCV status register with
// S-bit update, and an iterative shift-add multiplier that stalls intake.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_command,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             result_we,
  output logic [3:0]       status_register
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_MVN = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_ADC = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SBC = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_ORR = 4'd7;
  localparam logic [3:0] OP_EOR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_TST = 4'd10;
  localparam logic [3:0] OP_LDR = 4'd11;
  localparam logic [3:0] OP_STR = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t state, state_next;

  logic z_q, c_q, n_q, v_q;

  logic             accept;
  logic             is_mul;
  logic             last_step;

  logic [WIDTH:0]   res_ext;
  logic [WIDTH-1:0] res;
  logic             upd_nz, upd_cv, wr_en, c_res, v_res;

  logic [WIDTH-1:0] mcand, mplier, prod, prod_sum;
  logic [CW-1:0]    step_cnt;
  logic             mul_s;

  assign status_register = {z_q, c_q, n_q, v_q};
  assign in_ready        = (state == ST_IDLE);
  assign accept          = in_valid & in_ready;
  assign is_mul          = (alu_command == OP_MUL);
  assign last_step       = (state == ST_RUN) && (step_cnt == CW'(WIDTH - 1));
  assign res             = res_ext[WIDTH-1:0];
  assign prod_sum        = mplier[0] ? (prod + mcand) : prod;

  // Single-cycle datapath; arithmetic is carried one bit wider for C.
  always_comb begin
    res_ext = '0;
    upd_nz  = 1'b0;
    upd_cv  = 1'b0;
    wr_en   = 1'b1;
    c_res   = c_q;
    v_res   = v_q;
    case (alu_command)
      OP_MOV: begin
        res_ext = {1'b0, alu_in2};
        upd_nz  = set_flags;
      end
      OP_MVN: begin
        res_ext = {1'b0, ~alu_in2};
        upd_nz  = set_flags;
      end
      OP_ADD, OP_ADC: begin
        res_ext = {1'b0, alu_in1} + {1'b0, alu_in2}
                + {{WIDTH{1'b0}}, (alu_command == OP_ADC) ? c_q : 1'b0};
        upd_nz  = set_flags;
        upd_cv  = set_flags;
        c_res   = res_ext[WIDTH];
        v_res   = (alu_in1[MSB] == alu_in2[MSB]) & (res_ext[MSB] != alu_in1[MSB]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        // Subtraction as a + ~b + cin, so the carry out is NOT borrow.
        res_ext = {1'b0, alu_in1} + {1'b0, ~alu_in2}
                + {{WIDTH{1'b0}}, (alu_command == OP_SBC) ? c_q : 1'b1};
        upd_nz  = (alu_command == OP_CMP) ? 1'b1 : set_flags;
        upd_cv  = (alu_command == OP_CMP) ? 1'b1 : set_flags;
        wr_en   = (alu_command != OP_CMP);
        c_res   = res_ext[WIDTH];
        v_res   = (alu_in1[MSB] != alu_in2[MSB]) & (res_ext[MSB] != alu_in1[MSB]);
      end
      OP_AND, OP_TST: begin
        res_ext = {1'b0, alu_in1 & alu_in2};
        upd_nz  = (alu_command == OP_TST) ? 1'b1 : set_flags;
        wr_en   = (alu_command != OP_TST);
      end
      OP_ORR: begin
        res_ext = {1'b0, alu_in1 | alu_in2};
        upd_nz  = set_flags;
      end
      OP_EOR: begin
        res_ext = {1'b0, alu_in1 ^ alu_in2};
        upd_nz  = set_flags;
      end
      OP_LDR, OP_STR: begin
        res_ext = {1'b0, alu_in1} + {1'b0, alu_in2};
        wr_en   = (alu_command == OP_LDR);
      end
      OP_MUL: begin
        res_ext = '0;
      end
      default: begin
        res_ext = '0;
        wr_en   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_next = ST_RUN;
      ST_RUN:  if (last_step)        state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operands are latched at accept so bus changes during RUN cannot disturb the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      step_cnt <= '0;
      mul_s    <= 1'b0;
    end else if (state == ST_IDLE && accept && is_mul) begin
      mcand    <= alu_in1;
      mplier   <= alu_in2;
      prod     <= '0;
      step_cnt <= '0;
      mul_s    <= set_flags;
    end else if (state == ST_RUN) begin
      mcand    <= mcand << 1;
      mplier   <= mplier >> 1;
      prod     <= prod_sum;
      step_cnt <= step_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out   <= '0;
      out_valid <= 1'b0;
      result_we <= 1'b0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      result_we <= 1'b0;
      if (state == ST_IDLE && accept && !is_mul) begin
        alu_out   <= res;
        out_valid <= 1'b1;
        result_we <= wr_en;
        if (upd_nz) begin
          n_q <= res[MSB];
          z_q <= (res == '0);
        end
        if (upd_cv) begin
          c_q <= c_res;
          v_q <= v_res;
        end
      end else if (last_step) begin
        alu_out   <= prod_sum;
        out_valid <= 1'b1;
        result_we <= 1'b1;
        if (mul_s) begin
          n_q <= prod_sum[MSB];
          z_q <= (prod_sum == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: flags, handshake, MUL
// latency and reset abort, with hand-computed expected values.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_command;
  logic        set_flags;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        out_valid;
  logic [31:0] alu_out;
  logic        result_we;
  logic [3:0]  status_register;

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .alu_command     (alu_command),
    .set_flags       (set_flags),
    .alu_in1         (alu_in1),
    .alu_in2         (alu_in2),
    .out_valid       (out_valid),
    .alu_out         (alu_out),
    .result_we       (result_we),
    .status_register (status_register)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op for exactly one accept edge, then sample 1ns after it.
  task automatic applyStimulus(input logic [3:0] cmd, input logic s,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_command = cmd;
    set_flags   = s;
    alu_in1     = a;
    alu_in2     = b;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_out,
                             input logic exp_we, input logic [3:0] exp_status);
    check_val({tag, ".valid"},  32'(out_valid), 32'd1);
    check_val({tag, ".out"},    alu_out, exp_out);
    check_val({tag, ".we"},     32'(result_we), 32'(exp_we));
    check_val({tag, ".status"}, 32'(status_register), 32'(exp_status));
  endtask

  initial begin
    int edges;
    int spurious;
    logic done;

    rst         = 1'b0;
    in_valid    = 1'b0;
    alu_command = 4'd0;
    set_flags   = 1'b0;
    alu_in1     = '0;
    alu_in2     = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset.valid",  32'(out_valid), 32'd0);
    check_val("reset.we",     32'(result_we), 32'd0);
    check_val("reset.out",    alu_out, 32'd0);
    check_val("reset.status", 32'(status_register), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("reset.ready", 32'(in_ready), 32'd1);

    applyStimulus(4'd2, 1'b1, 32'h7FFF_FFFF, 32'h1);
    checkOutput("adds_ovf", 32'h8000_0000, 1'b1, 4'b0011);
    applyStimulus(4'd2, 1'b0, 32'h1, 32'h1);
    checkOutput("add_nos", 32'h2, 1'b1, 4'b0011);

    @(posedge clk);
    #1;
    check_val("idle.valid", 32'(out_valid), 32'd0);
    check_val("idle.we",    32'(result_we), 32'd0);
    check_val("idle.hold",  alu_out, 32'h2);

    applyStimulus(4'd4, 1'b1, 32'd5, 32'd5);
    checkOutput("subs_zero", 32'h0, 1'b1, 4'b1100);
    applyStimulus(4'd5, 1'b0, 32'd7, 32'd2);
    checkOutput("sbc_c1", 32'h5, 1'b1, 4'b1100);
    applyStimulus(4'd4, 1'b1, 32'd2, 32'd3);
    checkOutput("subs_borrow", 32'hFFFF_FFFF, 1'b1, 4'b0010);
    applyStimulus(4'd5, 1'b0, 32'd7, 32'd2);
    checkOutput("sbc_c0", 32'h4, 1'b1, 4'b0010);

    applyStimulus(4'd9, 1'b0, 32'd3, 32'd4);
    checkOutput("cmp", 32'hFFFF_FFFF, 1'b0, 4'b0010);
    applyStimulus(4'd12, 1'b1, 32'h100, 32'h8);
    checkOutput("str", 32'h108, 1'b0, 4'b0010);

    applyStimulus(4'd2, 1'b1, 32'h7FFF_FFFF, 32'h1);
    checkOutput("adds_v", 32'h8000_0000, 1'b1, 4'b0011);
    applyStimulus(4'd6, 1'b1, 32'hF0, 32'h0F);
    checkOutput("ands", 32'h0, 1'b1, 4'b1001);
    applyStimulus(4'd14, 1'b1, 32'h1234, 32'h5678);
    checkOutput("reserved", 32'h0, 1'b0, 4'b1001);

    applyStimulus(4'd4, 1'b1, 32'd0, 32'd0);
    checkOutput("subs_c1", 32'h0, 1'b1, 4'b1100);
    applyStimulus(4'd3, 1'b1, 32'h7FFF_FFFF, 32'h0);
    checkOutput("adcs", 32'h8000_0000, 1'b1, 4'b0011);
    applyStimulus(4'd4, 1'b1, 32'd5, 32'd5);
    checkOutput("subs_pre_mul", 32'h0, 1'b1, 4'b1100);

    // MUL with an ADD held on in_valid for the whole RUN phase.
    @(negedge clk);
    alu_command = 4'd13;
    set_flags   = 1'b1;
    alu_in1     = 32'h0000_FFFF;
    alu_in2     = 32'h0001_0001;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    check_val("mul.ready_low", 32'(in_ready), 32'd0);
    check_val("mul.no_valid",  32'(out_valid), 32'd0);
    @(negedge clk);
    alu_command = 4'd2;
    set_flags   = 1'b0;
    alu_in1     = 32'd3;
    alu_in2     = 32'd4;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (out_valid) done = 1'b1;
    end
    check_val("mul.latency", 32'(edges), 32'd32);
    checkOutput("muls", 32'hFFFF_FFFF, 1'b1, 4'b0110);
    check_val("mul.ready_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("add_after_mul", 32'h7, 1'b1, 4'b0110);
    @(negedge clk);
    in_valid = 1'b0;

    // Reset ten edges into a MUL must abort it without a completion.
    applyStimulus(4'd13, 1'b1, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("abort.valid",  32'(out_valid), 32'd0);
    check_val("abort.out",    alu_out, 32'd0);
    check_val("abort.we",     32'(result_we), 32'd0);
    check_val("abort.status", 32'(status_register), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) spurious++;
    end
    check_val("abort.spurious", 32'(spurious), 32'd0);
    check_val("abort.ready",    32'(in_ready), 32'd1);
    applyStimulus(4'd0, 1'b0, 32'h0, 32'h5);
    checkOutput("mov_after_abort", 32'h5, 1'b1, 4'b0000);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage ALU for the ARM pipeline. Adds a registered output stage with a valid handshake, an internal NZCV status register with per-instruction S-bit update, and correct ARM carry/borrow semantics. It also adds an iterative shift-add multiplier, so the unit accepts one operation per cycle except while a MUL is in progress. It sits between the ID/EX register and the EX/MEM register, and feeds the condition-check logic through `status_register`.

## Interface
- `WIDTH`, 32, datapath width in bits (≥ 4).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation presented this cycle.
- `in_ready`  out  1  unit can accept (high in IDLE).
- `alu_command`  in  4  opcode: 0 MOV, 1 MVN, 2 ADD, 3 ADC, 4 SUB, 5 SBC, 6 AND, 7 ORR, 8 EOR, 9 CMP, 10 TST, 11 LDR, 12 STR, 13 MUL, 14–15 reserved.
- `set_flags`  in  1  S bit; ignored for CMP/TST (always update) and LDR/STR/reserved (never update).
- `alu_in1`, `alu_in2`  in  WIDTH  operands (Rn, shifted operand2).
- `out_valid`  out  1  one-cycle pulse per accepted operation.
- `alu_out`  out  WIDTH  registered result, held until next `out_valid`.
- `result_we`  out  1  register write-back enable, qualified by `out_valid`; 0 for CMP, TST, STR, reserved.
- `status_register`  out  4  {Z, C, N, V}.

## Operation
- Accept = `in_valid & in_ready` at a rising edge. When `in_ready` is low, `in_valid` is ignored and the operation is not captured.
- FSM states:
  - IDLE: single-cycle ops complete at the accept edge; MUL accept → RUN.
  - RUN: one multiplier step per cycle; after WIDTH steps → IDLE.
- All arithmetic is WIDTH+1 bits wide; `alu_out` takes the low WIDTH bits.
- ADD: r = a + b. ADC: r = a + b + C.
  - C = bit WIDTH of the sum.
  - V = (a[msb] == b[msb]) & (r[msb] != a[msb]).
- SUB and CMP: r = a − b, computed as a + ~b + 1. SBC: r = a + ~b + C.
  - C = NOT borrow, i.e. the carry out of that sum.
  - V = (a[msb] != b[msb]) & (r[msb] != a[msb]).
- MOV: r = b. MVN: r = ~b. AND, ORR, EOR, TST: bitwise.
  - These update N and Z only; C and V are preserved.
- LDR and STR: r = a + b. Flags never change.
- MUL: r = low WIDTH bits of a × b, computed by shift-add (multiplicand left shift, multiplier right shift).
  - Updates N and Z when S is set; C and V are preserved.
- Reserved opcodes: r = 0, `result_we` = 0, no flag change, single cycle.
- N = r[msb]. Z = (r == 0) over WIDTH bits.
- C used by ADC/SBC is the register value at the accept edge. Because flags commit at that edge, an S-op followed back-to-back by ADC/SBC uses the updated C.

## Timing
- Reset (async) forces immediately:
  - state IDLE, multiplier state cleared;
  - `out_valid` 0, `result_we` 0, `alu_out` 0, `status_register` 4'b0000;
  - `in_ready` 1 from the first cycle after deassertion.
- Single-cycle ops: accept at edge E. `alu_out`, `result_we`, the flag update and `out_valid` are all visible in the cycle after E. Throughput is 1 per cycle.
- MUL: accept at edge E0, steps at edges E1…E_WIDTH.
  - `out_valid` and flags are visible after E_WIDTH, a latency of WIDTH edges.
  - `in_ready` is low after E0 through E_WIDTH, and high again in the `out_valid` cycle, so a new op may be accepted there.
- `out_valid` is low in every cycle without a completion. No output back-pressure.
- Reset during RUN aborts the MUL: no `out_valid` is ever produced for it, and flags go to 0.
- Operand or command changes while busy have no effect on the in-flight MUL, which uses operands captured at E0.

## Test plan
- ADDS 0x7FFFFFFF + 0x1 → next cycle: `alu_out` = 0x80000000, `result_we` = 1, status = 4'b0011. Then ADD (S=0) 1 + 1 → 0x2, status still 4'b0011.
- SUBS 5 − 5 → 0, status 4'b1100. Back-to-back SBC 7 − 2 → 5 (C=1).
  - Then SUBS 2 − 3 → 0xFFFFFFFF, status 4'b0010, followed by SBC 7 − 2 → 4.
- CMP 3, 4 → `alu_out` 0xFFFFFFFF, `result_we` 0, status 4'b0010. STR 0x100 + 0x8 → 0x108, `result_we` 0, flags unchanged.
- After ADDS giving V=1 (status 4'b0011): ANDS 0xF0 & 0x0F → 0, status 4'b1001 (C and V preserved).
- MULS 0x0000FFFF × 0x00010001 → `out_valid` exactly 32 edges after the accept edge, `alu_out` 0xFFFFFFFF, N=1, Z=0.
  - An ADD held on `in_valid` during RUN is accepted only in the `out_valid` cycle, and its result follows one cycle later.
- Assert `rst` 10 cycles into a MUL → all outputs 0 immediately. After release, no `out_valid` appears for 40 cycles, `in_ready` = 1, and a following MOV 0x5 returns 0x5.
